micro_sequencer: RTL and testbench

- Microcoded controller for the dedicated-processor datapath (8-entry register file, 3-bit aluOP ALU, RFSrcMuxSel constant mux, outBuf output register, aBTb comparator flag).
- Replaces hard-wired per-program FSMs: fetches 16-bit microinstructions from an external synchronous ROM, decodes them into datapath control, and handles unconditional/conditional jumps and halt.
- Provides a start/busy/done handshake to the top level and a runaway watchdog.

---
 rtl/micro_sequencer.sv | 166 ++++++++++++++++
 tb/tb_micro_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// micro_sequencer: microcoded controller for the dedicated-processor datapath.
// Define MSEQ_STEP_EN to add stepMode/step inputs that gate FETCH one instruction per pulse.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start after reset
// S_FETCH  | imemAddr = pc; ROM word arrives next cycle
// S_DECODE | capture ROM word into ir
// S_EXEC   | drive datapath controls from ir for one cycle, update pc
// S_DONE   | program halted or watchdog fired; waiting for start

module micro_sequencer #(
    parameter int PC_W      = 6,
    parameter int MAX_STEPS = 1023
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
`ifdef MSEQ_STEP_EN
    input  logic            stepMode,
    input  logic            step,
`endif
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [PC_W-1:0] imemAddr,
    input  logic [15:0]     imemData,
    output logic            RFSrcMuxSel,
    output logic [2:0]      readAddr1,
    output logic [2:0]      readAddr2,
    output logic [2:0]      writeAddr,
    output logic            writeEn,
    output logic            outBuf,
    output logic [2:0]      aluOP,
    input  logic            aBTb
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_EXEC = 2'b00;
    localparam logic [1:0] OP_JMP  = 2'b01;
    localparam logic [1:0] OP_BRT  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam bit         WDOG_EN    = (MAX_STEPS != 0);
    localparam logic [9:0] STEP_LIMIT = 10'(MAX_STEPS);

    state_t            state, state_n;
    logic [PC_W-1:0]   pc, pc_n;
    logic [15:0]       ir, ir_n;
    logic [9:0]        step_cnt, step_cnt_n;
    logic              err_q, err_n;

    logic [1:0]        op;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   target;
    logic              fetch_go;

    assign op     = ir[15:14];
    assign target = ir[PC_W-1:0];
    assign pc_inc = pc + PC_W'(1);

`ifdef MSEQ_STEP_EN
    assign fetch_go = !stepMode || step;
`else
    assign fetch_go = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            step_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            step_cnt <= step_cnt_n;
            err_q    <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        ir_n        = ir;
        step_cnt_n  = step_cnt;
        err_n       = err_q;
        RFSrcMuxSel = 1'b0;
        readAddr1   = 3'd0;
        readAddr2   = 3'd0;
        writeAddr   = 3'd0;
        writeEn     = 1'b0;
        outBuf      = 1'b0;
        aluOP       = 3'd0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n    = S_FETCH;
                    pc_n       = '0;
                    step_cnt_n = '0;
                    err_n      = 1'b0;
                end
            end

            S_FETCH: begin
                if (fetch_go) begin
                    state_n = S_DECODE;
                end
            end

            S_DECODE: begin
                ir_n    = imemData;
                state_n = S_EXEC;
            end

            S_EXEC: begin
                case (op)
                    OP_EXEC: begin
                        RFSrcMuxSel = ir[13];
                        readAddr1   = ir[12:10];
                        readAddr2   = ir[9:7];
                        writeAddr   = ir[6:4];
                        writeEn     = 1'b1;
                        outBuf      = ir[3];
                        aluOP       = ir[2:0];
                        pc_n        = pc_inc;
                    end
                    OP_JMP:  pc_n = target;
                    OP_BRT:  pc_n = aBTb ? target : pc_inc;
                    default: pc_n = pc;
                endcase

                if (op == OP_HALT) begin
                    state_n = S_DONE;
                end else begin
                    // The watchdog trips on the instruction that brings the retired count to the limit.
                    step_cnt_n = step_cnt + 10'd1;
                    if (WDOG_EN && (step_cnt_n == STEP_LIMIT)) begin
                        state_n = S_DONE;
                        err_n   = 1'b1;
                    end else begin
                        state_n = S_FETCH;
                    end
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    assign busy     = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
    assign done     = (state == S_DONE);
    assign err      = err_q;
    assign imemAddr = pc;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: an instruction-level interpreter builds the
// expected per-cycle output trace of each run, and one process compares the DUT against it.

`timescale 1ns/1ps

module tb_micro_sequencer;

    localparam int PC_W  = 6;
    localparam int DEPTH = 64;
    localparam int MAXS  = 8;
    localparam int MAXC  = 3 * MAXS + 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        aBTb = 1'b0;
    logic [15:0] imemData = 16'h0000;
    logic        busy, done, err;
    logic [5:0]  imemAddr;
    logic        RFSrcMuxSel, writeEn, outBuf;
    logic [2:0]  readAddr1, readAddr2, writeAddr, aluOP;
`ifdef MSEQ_STEP_EN
    logic        stepMode = 1'b0;
    logic        step = 1'b0;
`endif

    micro_sequencer #(.PC_W(PC_W), .MAX_STEPS(MAXS)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
`ifdef MSEQ_STEP_EN
        .stepMode(stepMode),
        .step(step),
`endif
        .busy(busy),
        .done(done),
        .err(err),
        .imemAddr(imemAddr),
        .imemData(imemData),
        .RFSrcMuxSel(RFSrcMuxSel),
        .readAddr1(readAddr1),
        .readAddr2(readAddr2),
        .writeAddr(writeAddr),
        .writeEn(writeEn),
        .outBuf(outBuf),
        .aluOP(aluOP),
        .aBTb(aBTb)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [DEPTH];
    always @(posedge clk) imemData <= rom[imemAddr];

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic [5:0] addr;
        logic       rf;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] wa;
        logic       we;
        logic       ob;
        logic [2:0] alu;
    } obs_t;

    obs_t dut_o;
    assign dut_o = {busy, done, err, imemAddr, RFSrcMuxSel, readAddr1, readAddr2,
                    writeAddr, writeEn, outBuf, aluOP};

    obs_t exp_tr [MAXC];
    obs_t act_tr [MAXC];
    bit   abtb_tr [MAXC];
    bit   start_tr [MAXC];
    int   cidx = 0;
    bit   chk_on = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            act_tr[cidx] = dut_o;
            checks++;
            if (dut_o !== exp_tr[cidx]) begin
                failures++;
                $display("FAIL trace cycle=%0d actual=0x%06h required=0x%06h",
                         cidx, dut_o, exp_tr[cidx]);
            end
        end
    end

    // Interpret the ROM one instruction at a time; each instruction spans three cycles
    // (fetch, decode, exec) counted from the cycle after the start edge.
    task automatic build_trace();
        int pc, steps, c;
        bit fin, e;
        logic [15:0] ins;
        obs_t o;
        pc = 0; steps = 0; c = 0; fin = 1'b0; e = 1'b0;
        while (!fin) begin
            o = '0;
            o.busy = 1'b1;
            o.addr = 6'(pc);
            exp_tr[c]     = o;
            exp_tr[c + 1] = o;
            ins = rom[pc];
            if (ins[15:14] == 2'b00) begin
                o.rf  = ins[13];
                o.ra  = ins[12:10];
                o.rb  = ins[9:7];
                o.wa  = ins[6:4];
                o.we  = 1'b1;
                o.ob  = ins[3];
                o.alu = ins[2:0];
            end
            exp_tr[c + 2] = o;
            case (ins[15:14])
                2'b00:   pc = (pc + 1) % DEPTH;
                2'b01:   pc = int'(ins[5:0]);
                2'b10:   pc = abtb_tr[c + 2] ? int'(ins[5:0]) : (pc + 1) % DEPTH;
                default: fin = 1'b1;
            endcase
            if (ins[15:14] != 2'b11) begin
                steps++;
                if (steps == MAXS) begin
                    fin = 1'b1;
                    e   = 1'b1;
                end
            end
            c += 3;
        end
        for (int k = c; k < MAXC; k++) begin
            o = '0;
            o.done = 1'b1;
            o.err  = e;
            o.addr = 6'(pc);
            exp_tr[k] = o;
        end
    endtask

    // abtb_mode: 0 or 1 forces aBTb, 2 randomises it every cycle.
    task automatic run_prog(input int abtb_mode);
        for (int c = 0; c < MAXC; c++)
            abtb_tr[c] = (abtb_mode == 2) ? bit'($urandom_range(0, 1)) : (abtb_mode == 1);
        build_trace();
        for (int c = 0; c < MAXC; c++)
            start_tr[c] = exp_tr[c].busy && ($urandom_range(0, 7) == 0);
        start = 1'b1;
        aBTb  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        for (int c = 0; c < MAXC; c++) begin
            start  = start_tr[c];
            aBTb   = abtb_tr[c];
            cidx   = c;
            chk_on = 1'b1;
            @(posedge clk); #1;
        end
        chk_on = 1'b0;
        start  = 1'b0;
    endtask

    task automatic rom_fill_halt();
        for (int i = 0; i < DEPTH; i++) rom[i] = 16'hC000;
    endtask

    initial begin
        int n;
        int r;
        rom_fill_halt();

        repeat (3) @(posedge clk);
        #1 chk("reset_state", 32'(dut_o), 32'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // R3 = 1 then HALT
        rom_fill_halt();
        rom[0] = 16'h2030;
        run_prog(2);
        chk("halt_prog_we", 32'(act_tr[2].we), 32'h1);
        chk("halt_prog_wa", 32'(act_tr[2].wa), 32'h3);
        chk("halt_prog_rf", 32'(act_tr[2].rf), 32'h1);
        chk("halt_prog_done_busy_err", {29'h0, act_tr[6].done, act_tr[6].busy, act_tr[6].err}, 32'h4);

        // BRT at address 5, taken and not taken
        rom_fill_halt();
        rom[0] = 16'h4005;
        rom[5] = 16'h8002;
        run_prog(1);
        chk("brt_taken_addr", 32'(act_tr[6].addr), 32'd2);
        chk("brt_taken_we", 32'(act_tr[5].we), 32'h0);
        run_prog(0);
        chk("brt_not_taken_addr", 32'(act_tr[6].addr), 32'd6);
        chk("brt_not_taken_we", 32'(act_tr[5].we), 32'h0);

        // self-loop JMP runs into the watchdog after MAXS exec cycles
        rom_fill_halt();
        rom[0] = 16'h4000;
        run_prog(2);
        chk("wdog_not_yet_done", 32'(act_tr[3 * MAXS - 1].done), 32'h0);
        chk("wdog_done_busy_err", {29'h0, act_tr[3 * MAXS].done, act_tr[3 * MAXS].busy,
                                   act_tr[3 * MAXS].err}, 32'h5);
        run_prog(2);
        chk("restart_clears_err", {29'h0, act_tr[0].done, act_tr[0].busy, act_tr[0].err}, 32'h2);

        // pc wrap from the last ROM word back to 0
        rom_fill_halt();
        rom[0]  = 16'h403F;
        rom[63] = 16'h0490;
        run_prog(2);
        chk("wrap_exec_we", 32'(act_tr[5].we), 32'h1);
        chk("wrap_next_addr", 32'(act_tr[6].addr), 32'h0);

        // random programs
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                r = $urandom_range(0, 9);
                rom[i] = {(r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11,
                          14'($urandom)};
            end
            run_prog(2);
        end

        // asynchronous reset in the middle of an R1=R1+R1 exec cycle
        rom_fill_halt();
        rom[0] = 16'h0490;
        rom[1] = 16'h0490;
        rom[2] = 16'h0490;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("pre_reset_we", 32'(writeEn), 32'h1);
        #2 reset = 1'b0;
        #1 chk("mid_exec_reset_outputs", 32'(dut_o), 32'h0);
        @(negedge clk) reset = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            n += int'(writeEn);
        end
        chk("post_reset_no_writes", 32'(n), 32'h0);
        @(posedge clk); #1;

`ifdef MSEQ_STEP_EN
        rom_fill_halt();
        rom[0] = 16'h2030;
        rom[1] = 16'h0490;
        stepMode = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            n += int'(writeEn);
        end
        chk("step_hold_no_exec", 32'(n), 32'h0);
        chk("step_hold_busy_addr", {25'h0, busy, imemAddr}, {25'h0, 1'b1, 6'd0});
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("step_start_ignored", {25'h0, busy, imemAddr}, {25'h0, 1'b1, 6'd0});
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            n += int'(writeEn);
        end
        chk("step_one_exec", 32'(n), 32'h1);
        chk("step_held_next_addr", 32'(imemAddr), 32'h1);
        stepMode = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("step_release_done", {30'h0, done, err}, 32'h2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
